// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_add_core.sv
// Sequential unsigned shift-add multiplier: one partial product per step, W steps per op.
module shift_add_core
  import mult_sched_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = idx_w(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           last_step,
  output logic [2*W-1:0] result
);

  logic [2*W-1:0] mcand_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;

  always_comb begin
    acc_nxt = acc_q;
    if (mplier_q[0]) begin
      acc_nxt = acc_q + mcand_q;
    end
  end

  // Accumulator value after the step currently being executed.
  assign result    = acc_nxt;
  assign last_step = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin arbiter sharing one shift-add multiplier among NREQ requesters.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned IDW  = idx_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [2*W-1:0]    product
);

  state_e state_q, state_d;

  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  cur_q, cur_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic [2*W-1:0]  product_q, product_d;

  logic [IDW-1:0]  pick;
  logic            core_load;
  logic            core_step;
  logic            core_last;
  logic [2*W-1:0]  core_result;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;

  // Rotating priority: search starts just after the last winner and wraps.
  always_comb begin
    int unsigned j;
    logic        found;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = k + {{(32 - IDW){1'b0}}, last_q};
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IDW'(j);
      end
    end
  end

  assign a_sel = a_in[pick*W +: W];
  assign b_sel = b_in[pick*W +: W];

  shift_add_core #(
    .W (W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (core_load),
    .step      (core_step),
    .a         (a_sel),
    .b         (b_sel),
    .last_step (core_last),
    .result    (core_result)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cur_d     = cur_q;
    grant_d   = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    product_d = product_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d   = StRun;
          core_load = 1'b1;
          grant_d   = NREQ'(1) << pick;
          last_d    = pick;
          cur_d     = pick;
          busy_d    = 1'b1;
        end
      end
      StRun: begin
        core_step = 1'b1;
        if (core_last) begin
          state_d   = StFin;
          done_d    = 1'b1;
          product_d = core_result;
          done_id_d = cur_q;
        end else begin
          busy_d = 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= IDW'(NREQ - 1);
      cur_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      product_q <= product_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: directed scenarios plus randomized ops vs. a reference model.
module tb_mult_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [2*W-1:0]    product;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int exp_last;

  mult_sched #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .product (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: first requester after 'last' in circular order.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [2*W-1:0] ref_prod(input int i);
    int unsigned x;
    int unsigned y;
    x = a_in[i*W +: W];
    y = b_in[i*W +: W];
    return (2*W)'(x * y);
  endfunction

  task automatic set_ops(input int i, input int a, input int b);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
  endtask

  // Waits (bounded) for a grant, drops that requester, then waits (bounded) for done.
  task automatic observe_op(output logic [NREQ-1:0] g, output int gcyc, output logic g_after,
                            output logic busy_g, output int lat, output logic [2*W-1:0] p,
                            output logic [IDW-1:0] id, output logic busy_d, output logic to);
    to = 1'b0; g = '0; gcyc = 0; g_after = 1'b0; busy_g = 1'b0;
    lat = 0; p = '0; id = '0; busy_d = 1'b0;
    for (int i = 0; i < 40 && g == '0; i++) begin
      @(posedge clk); #1;
      if (grant != '0) begin
        g      = grant;
        busy_g = busy;
        gcyc   = cyc;
      end
    end
    if (g == '0) begin
      to = 1'b1;
      return;
    end
    req = req & ~g;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) g_after = |grant;
      if (done) break;
    end
    if (!done) begin
      to = 1'b1;
      return;
    end
    p      = product;
    id     = done_id;
    busy_d = busy;
  endtask

  task automatic test_reset();
    logic [NREQ-1:0] g_seen;
    logic            any_busy;
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({grant, busy, done, done_id, product} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0", {grant, busy, done, done_id, product});
    end
    @(negedge clk) rst = 1'b0;
    g_seen = '0;
    any_busy = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      g_seen   = g_seen | grant;
      any_busy = any_busy | busy | done;
    end
    n_cmp++;
    if (g_seen !== '0 || any_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_quiet: grant %b busy/done %b required 0", g_seen, any_busy);
    end
    exp_last = NREQ - 1;
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] g, order [5];
    logic            g_after, busy_g, busy_d, to;
    logic [2*W-1:0]  p, ep;
    logic [IDW-1:0]  id;
    int              gcyc, prev, lat, w;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < NREQ; i++) set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255));
    req  = '1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      w  = rr_pick(req, exp_last);
      ep = ref_prod(w);
      observe_op(g, gcyc, g_after, busy_g, lat, p, id, busy_d, to);
      n_cmp++;
      if (to || g !== order[k] || g !== onehot(w)) begin
        n_bad++;
        $display("FAIL contention_grant[%0d]: got %b timeout %b required %b", k, g, to, order[k]);
      end
      n_cmp++;
      if (id !== IDW'(w) || p !== ep) begin
        n_bad++;
        $display("FAIL contention_result[%0d]: got id %0d prod %0d required id %0d prod %0d",
                 k, id, p, w, ep);
      end
      if (k > 0) begin
        n_cmp++;
        if (gcyc - prev !== W + 2) begin
          n_bad++;
          $display("FAIL contention_spacing[%0d]: got %0d cycles required %0d", k, gcyc - prev,
                   W + 2);
        end
      end
      prev     = gcyc;
      exp_last = w;
      req      = req | g;
    end
    req = '0;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g;
    logic            g_after, busy_g, busy_d, to;
    logic [2*W-1:0]  p;
    logic [IDW-1:0]  id;
    int              gcyc, lat;
    req = 4'b0001;
    set_ops(0, 12, 13);
    observe_op(g, gcyc, g_after, busy_g, lat, p, id, busy_d, to);
    n_cmp++;
    if (to || g !== 4'b0001 || g_after !== 1'b0 || busy_g !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: got %b after %b busy %b timeout %b required 0001 0 1 0",
               g, g_after, busy_g, to);
    end
    n_cmp++;
    if (lat !== W || p !== 16'd156 || id !== 2'd0 || busy_d !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done: got lat %0d prod %0d id %0d busy %b required %0d 156 0 0",
               lat, p, id, busy_d, W);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL single_after: got busy %b done %b required 0 0", busy, done);
    end
    exp_last = 0;
  endtask

  task automatic test_extremes();
    logic [NREQ-1:0] g;
    logic            g_after, busy_g, busy_d, to;
    logic [2*W-1:0]  p, ep;
    logic [IDW-1:0]  id;
    int              gcyc, lat;
    int              ta [3];
    int              tb [3];
    ta = '{255, 0, 1};
    tb = '{255, 200, 1};
    for (int k = 0; k < 3; k++) begin
      req = 4'b0001;
      set_ops(0, ta[k], tb[k]);
      ep = (2*W)'(ta[k] * tb[k]);
      observe_op(g, gcyc, g_after, busy_g, lat, p, id, busy_d, to);
      n_cmp++;
      if (to || p !== ep || lat !== W || id !== 2'd0) begin
        n_bad++;
        $display("FAIL extreme[%0d]: got prod %0d lat %0d id %0d timeout %b required %0d %0d 0",
                 k, p, lat, id, to, ep, W);
      end
    end
    exp_last = 0;
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] g;
    logic            g_after, busy_g, busy_d, to;
    logic [2*W-1:0]  p;
    logic [IDW-1:0]  id;
    int              gcyc, lat;
    req = 4'b0010;
    set_ops(1, 2, 3);
    observe_op(g, gcyc, g_after, busy_g, lat, p, id, busy_d, to);
    n_cmp++;
    if (to || g !== 4'b0010 || p !== 16'd6) begin
      n_bad++;
      $display("FAIL fair_setup: got %b prod %0d required 0010 6", g, p);
    end
    req = 4'b1001;
    set_ops(0, 20, 30);
    set_ops(3, 40, 50);
    observe_op(g, gcyc, g_after, busy_g, lat, p, id, busy_d, to);
    n_cmp++;
    if (to || g !== 4'b1000 || id !== 2'd3 || p !== 16'd2000) begin
      n_bad++;
      $display("FAIL fair_skip: got %b id %0d prod %0d required 1000 3 2000", g, id, p);
    end
    observe_op(g, gcyc, g_after, busy_g, lat, p, id, busy_d, to);
    n_cmp++;
    if (to || g !== 4'b0001 || id !== 2'd0 || p !== 16'd600) begin
      n_bad++;
      $display("FAIL fair_wrap: got %b id %0d prod %0d required 0001 0 600", g, id, p);
    end
    exp_last = 0;
  endtask

  task automatic test_operand_hold();
    logic seen_g, seen_d;
    req = 4'b0100;
    set_ops(2, 10, 10);
    seen_g = 1'b0;
    for (int i = 0; i < 40 && !seen_g; i++) begin
      @(posedge clk); #1;
      seen_g = |grant;
    end
    req = '0;
    set_ops(2, 99, 99);
    seen_d = 1'b0;
    for (int i = 0; i < 40 && !seen_d; i++) begin
      @(posedge clk); #1;
      seen_d = done;
    end
    n_cmp++;
    if (!seen_g || !seen_d || product !== 16'd100 || done_id !== 2'd2) begin
      n_bad++;
      $display("FAIL operand_hold: got prod %0d id %0d grant %b done %b required 100 2 1 1",
               product, done_id, seen_g, seen_d);
    end
    exp_last = 2;
  endtask

  task automatic test_reset_mid_op();
    logic [NREQ-1:0] g;
    logic            g_after, busy_g, busy_d, to, seen_g, saw_done;
    logic [2*W-1:0]  p;
    logic [IDW-1:0]  id;
    int              gcyc, lat;
    req = 4'b0001;
    set_ops(0, 7, 9);
    seen_g = 1'b0;
    for (int i = 0; i < 40 && !seen_g; i++) begin
      @(posedge clk); #1;
      seen_g = |grant;
    end
    req = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (!seen_g || {grant, busy, done, done_id, product} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_op: got %h granted %b required 0 1",
               {grant, busy, done, done_id, product}, seen_g);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw_done = saw_done | done;
    end
    @(negedge clk) rst = 1'b0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      saw_done = saw_done | done;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_done: got done %b required 0", saw_done);
    end
    exp_last = NREQ - 1;
    req = 4'b1001;
    set_ops(0, 3, 5);
    set_ops(3, 6, 7);
    observe_op(g, gcyc, g_after, busy_g, lat, p, id, busy_d, to);
    n_cmp++;
    if (to || g !== 4'b0001 || p !== 16'd15 || lat !== W) begin
      n_bad++;
      $display("FAIL post_reset_op: got %b prod %0d lat %0d required 0001 15 %0d", g, p, lat, W);
    end
    observe_op(g, gcyc, g_after, busy_g, lat, p, id, busy_d, to);
    n_cmp++;
    if (to || g !== 4'b1000 || p !== 16'd42 || id !== 2'd3) begin
      n_bad++;
      $display("FAIL post_reset_next: got %b prod %0d id %0d required 1000 42 3", g, p, id);
    end
    exp_last = 3;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g;
    logic            g_after, busy_g, busy_d, to;
    logic [2*W-1:0]  p, ep;
    logic [IDW-1:0]  id;
    int              gcyc, lat, w;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255));
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      w   = rr_pick(req, exp_last);
      ep  = ref_prod(w);
      observe_op(g, gcyc, g_after, busy_g, lat, p, id, busy_d, to);
      req = '0;
      n_cmp++;
      if (to || g !== onehot(w) || id !== IDW'(w) || p !== ep || lat !== W || g_after !== 1'b0) begin
        n_bad++;
        $display("FAIL random[%0d]: got grant %b id %0d prod %0d lat %0d required %b %0d %0d %0d",
                 k, g, id, p, lat, onehot(w), w, ep, W);
      end
      exp_last = w;
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_extremes();
    test_fairness();
    test_operand_hold();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
